// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_monitor
// Purpose  : Passive checker for Red/Yellow/Green lamp outputs of a traffic
//            light controller. Locks onto the lamp sequence, verifies one-hot
//            encoding, legal phase order (R -> G -> Y -> R) and exact per-phase
//            dwell lengths, counts complete good cycles and reports errors.
// Ports    : clk        - clock, all logic on posedge
//            rst        - synchronous reset, active-low (0 = reset)
//            Red        - red lamp sample
//            Yellow     - yellow lamp sample
//            Green      - green lamp sample
//            phase      - tracked phase: 0 SYNC/FAULT, 1 RED, 2 GREEN, 3 YELLOW
//            cycle_done - one-cycle pulse per complete good R-G-Y cycle
//            cycle_cnt  - good cycle count, wraps 255 -> 0
//            err_pulse  - one-cycle pulse per detected violation
//            err_code   - first error since reset: 0 none, 1 one-hot,
//                         2 sequence, 3 dwell short, 4 dwell long
//            fault      - sticky error flag
// Options  : TRAFFIC_MON_AUTO_RESYNC_EN - when defined, FAULT lasts a single
//            cycle and monitoring resumes from SYNC; otherwise FAULT holds
//            until reset.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_light_monitor #(
    parameter int RED_LEN    = 11,
    parameter int GREEN_LEN  = 6,
    parameter int YELLOW_LEN = 5,
    parameter int CNT_W      = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Red,
    input  logic       Yellow,
    input  logic       Green,
    output logic [1:0] phase,
    output logic       cycle_done,
    output logic [7:0] cycle_cnt,
    output logic       err_pulse,
    output logic [2:0] err_code,
    output logic       fault
);

    // Active states share their low two bits with the lamp code of the lamp
    // that phase expects, so the expected lamp is simply r_state[1:0].
    localparam logic [2:0] c_ST_SYNC   = 3'd0;
    localparam logic [2:0] c_ST_RED    = 3'd1;
    localparam logic [2:0] c_ST_GREEN  = 3'd2;
    localparam logic [2:0] c_ST_YELLOW = 3'd3;
    localparam logic [2:0] c_ST_FAULT  = 3'd4;

    localparam logic [1:0] c_LAMP_NONE = 2'd0;
    localparam logic [1:0] c_LAMP_R    = 2'd1;
    localparam logic [1:0] c_LAMP_G    = 2'd2;
    localparam logic [1:0] c_LAMP_Y    = 2'd3;

    localparam logic [2:0] c_ERR_NONE  = 3'd0;
    localparam logic [2:0] c_ERR_HOT   = 3'd1;
    localparam logic [2:0] c_ERR_SEQ   = 3'd2;
    localparam logic [2:0] c_ERR_SHORT = 3'd3;
    localparam logic [2:0] c_ERR_LONG  = 3'd4;

    localparam logic [CNT_W-1:0] c_RED_LEN    = CNT_W'(RED_LEN);
    localparam logic [CNT_W-1:0] c_GREEN_LEN  = CNT_W'(GREEN_LEN);
    localparam logic [CNT_W-1:0] c_YELLOW_LEN = CNT_W'(YELLOW_LEN);
    localparam logic [CNT_W-1:0] c_DWELL_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_DWELL_MAX  = {CNT_W{1'b1}};

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_dwell;
    logic [1:0]       r_prev;

    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_dwell_nxt;
    logic [1:0]       w_prev_nxt;
    logic             w_err;
    logic [2:0]       w_err_type;
    logic             w_done;

    logic             w_onehot;
    logic [1:0]       w_lamp;
    logic [1:0]       w_cur_lamp;
    logic [1:0]       w_next_lamp;
    logic [CNT_W-1:0] w_cur_len;

    // Lamp sample decode; anything other than exactly one lamp is invalid.
    always_comb begin
        w_onehot = 1'b1;
        w_lamp   = c_LAMP_NONE;
        case ({Red, Yellow, Green})
            3'b100:  w_lamp = c_LAMP_R;
            3'b010:  w_lamp = c_LAMP_Y;
            3'b001:  w_lamp = c_LAMP_G;
            default: w_onehot = 1'b0;
        endcase
    end

    // Expected lamp, its legal successor and the required dwell of the
    // phase currently being tracked.
    always_comb begin
        w_cur_lamp  = r_state[1:0];
        w_next_lamp = (w_cur_lamp == c_LAMP_Y) ? c_LAMP_R : (w_cur_lamp + 2'd1);
        case (r_state)
            c_ST_RED:    w_cur_len = c_RED_LEN;
            c_ST_GREEN:  w_cur_len = c_GREEN_LEN;
            c_ST_YELLOW: w_cur_len = c_YELLOW_LEN;
            default:     w_cur_len = c_RED_LEN;
        endcase
    end

    // ------------------------------------------------------------------
    // State register (also holds the registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_ST_SYNC;
            r_dwell    <= '0;
            r_prev     <= c_LAMP_NONE;
            cycle_done <= 1'b0;
            cycle_cnt  <= 8'd0;
            err_pulse  <= 1'b0;
            err_code   <= c_ERR_NONE;
            fault      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dwell    <= w_dwell_nxt;
            r_prev     <= w_prev_nxt;
            cycle_done <= w_done;
            cycle_cnt  <= cycle_cnt + {7'd0, w_done};
            err_pulse  <= w_err;
            fault      <= fault | w_err;
            // Only the first violation since reset is recorded.
            if (w_err && (err_code == c_ERR_NONE)) begin
                err_code <= w_err_type;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_dwell_nxt = r_dwell;
        w_prev_nxt  = r_prev;
        w_err       = 1'b0;
        w_err_type  = c_ERR_NONE;
        w_done      = 1'b0;

        case (r_state)
            c_ST_SYNC: begin
                if (!w_onehot) begin
                    w_err      = 1'b1;
                    w_err_type = c_ERR_HOT;
                end else begin
                    w_prev_nxt = w_lamp;
                    // Lock on at the Yellow -> Red boundary so the first
                    // tracked Red phase starts at a known dwell of one.
                    if ((r_prev == c_LAMP_Y) && (w_lamp == c_LAMP_R)) begin
                        w_state_nxt = c_ST_RED;
                        w_dwell_nxt = c_DWELL_ONE;
                    end
                end
            end

            c_ST_RED, c_ST_GREEN, c_ST_YELLOW: begin
                if (!w_onehot) begin
                    w_err      = 1'b1;
                    w_err_type = c_ERR_HOT;
                end else if (w_lamp == w_cur_lamp) begin
                    // Incrementing onto LEN+1 means the dwell is already LEN.
                    if (r_dwell == w_cur_len) begin
                        w_err      = 1'b1;
                        w_err_type = c_ERR_LONG;
                    end else if (r_dwell != c_DWELL_MAX) begin
                        w_dwell_nxt = r_dwell + c_DWELL_ONE;
                    end
                end else if (w_lamp == w_next_lamp) begin
                    if (r_dwell == w_cur_len) begin
                        w_state_nxt = {1'b0, w_next_lamp};
                        w_dwell_nxt = c_DWELL_ONE;
                        w_done      = (r_state == c_ST_YELLOW);
                    end else begin
                        w_err      = 1'b1;
                        w_err_type = c_ERR_SHORT;
                    end
                end else begin
                    w_err      = 1'b1;
                    w_err_type = c_ERR_SEQ;
                end
            end

            c_ST_FAULT: begin
`ifdef TRAFFIC_MON_AUTO_RESYNC_EN
                w_state_nxt = c_ST_SYNC;
`else
                w_state_nxt = c_ST_FAULT;
`endif
            end

            default: begin
                w_state_nxt = c_ST_SYNC;
                w_dwell_nxt = '0;
                w_prev_nxt  = c_LAMP_NONE;
            end
        endcase

        // Any violation drops tracking; a later resync must see Y then R anew.
        if (w_err) begin
            w_state_nxt = c_ST_FAULT;
            w_dwell_nxt = '0;
            w_prev_nxt  = c_LAMP_NONE;
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        case (r_state)
            c_ST_RED:    phase = 2'd1;
            c_ST_GREEN:  phase = 2'd2;
            c_ST_YELLOW: phase = 2'd3;
            default:     phase = 2'd0;
        endcase
    end

endmodule
`default_nettype wire
